// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the OAM sprite DMA controller: bus widths,
// default trigger/destination addresses and the sequencer state type.
package oam_dma_ctrl_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    // CPU write address that kicks off a sprite DMA (data = source page)
    localparam logic [ADDR_WIDTH-1:0] OAM_DMA_ADDR  = 16'h4014;
    // Sprite data port every DMA byte is written to
    localparam logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004;
    // Bytes moved per DMA
    localparam int OAM_XFER_LEN = 256;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT_WAIT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // True when the CPU cycle is a write to the DMA trigger register
    function automatic logic is_trigger(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic                  r_w_n,
                                        input logic [ADDR_WIDTH-1:0] trig_addr);
        return (!r_w_n) && (addr == trig_addr);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM sprite DMA sequencer and memory-bus arbiter between the 6502 core
// and memory. A CPU write of page P to TRIGGER_ADDR halts the CPU and
// copies XFER_LEN bytes from {P,8'h00}.. to DEST_ADDR, one read/write
// pair per byte. Optional macro DMA_ODD_ALIGN_EN adds an extra ALIGN
// cycle whenever the parity counter is odd while aligning.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = OAM_DMA_ADDR,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = OAM_DATA_ADDR,
    parameter int                    XFER_LEN     = OAM_XFER_LEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_r_w_n,
    input  logic [REG_WIDTH-1:0]  cpu_dout,
    output logic [REG_WIDTH-1:0]  cpu_din,
    output logic                  cpu_rdy,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_r_w_n,
    output logic [REG_WIDTH-1:0]  bus_dout,
    input  logic [REG_WIDTH-1:0]  bus_din,
    output logic                  dma_busy,
    output logic                  dma_done
);

    localparam logic [8:0] LAST_IDX = 9'(XFER_LEN - 1);

`ifdef DMA_ODD_ALIGN_EN
    localparam logic ODD_ALIGN = 1'b1;
`else
    localparam logic ODD_ALIGN = 1'b0;
`endif

    dma_state_t           state;
    dma_state_t           state_next;
    logic [8:0]           idx;
    logic [7:0]           page;
    logic [REG_WIDTH-1:0] data_q;
    logic                 parity;
    logic                 trigger;
    logic                 last_byte;
    logic                 align_hold;

    assign trigger    = is_trigger(cpu_addr, cpu_r_w_n, TRIGGER_ADDR);
    assign last_byte  = (idx == LAST_IDX);
    assign align_hold = ODD_ALIGN && parity;
    assign cpu_din    = bus_din;

    // State register; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DMA_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing: trigger, wait for CPU read, align, then read/write pairs
    always_comb begin
        state_next = state;
        case (state)
            DMA_IDLE:      if (trigger)     state_next = DMA_HALT_WAIT;
            DMA_HALT_WAIT: if (cpu_r_w_n)   state_next = DMA_ALIGN;
            DMA_ALIGN:     if (!align_hold) state_next = DMA_READ;
            DMA_READ:      state_next = DMA_WRITE;
            DMA_WRITE:     state_next = last_byte ? DMA_IDLE : DMA_READ;
            default:       state_next = DMA_IDLE;
        endcase
    end

    // Transfer datapath: source page, byte index, read data latch, parity and done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx      <= '0;
            page     <= '0;
            data_q   <= '0;
            parity   <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            parity   <= ~parity;
            dma_done <= (state == DMA_WRITE) && last_byte;
            if ((state == DMA_IDLE) && trigger) begin
                page <= cpu_dout[7:0];
                idx  <= '0;
            end
            if (state == DMA_READ) begin
                data_q <= bus_din;
            end
            if ((state == DMA_WRITE) && !last_byte) begin
                idx <= idx + 9'd1;
            end
        end
    end

    // Bus ownership mux plus CPU halt and busy flags derived from the state
    always_comb begin
        bus_addr  = cpu_addr;
        bus_r_w_n = cpu_r_w_n;
        bus_dout  = cpu_dout;
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;
        case (state)
            DMA_IDLE: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
            end
            DMA_HALT_WAIT: begin
                cpu_rdy  = 1'b0;
            end
            DMA_ALIGN: begin
                bus_addr  = DEST_ADDR;
                bus_r_w_n = 1'b1;
                bus_dout  = data_q;
            end
            DMA_READ: begin
                bus_addr  = {page, idx[7:0]};
                bus_r_w_n = 1'b1;
                bus_dout  = data_q;
            end
            DMA_WRITE: begin
                bus_addr  = DEST_ADDR;
                bus_r_w_n = 1'b0;
                bus_dout  = data_q;
            end
            default: begin
                cpu_rdy  = 1'b1;
                dma_busy = 1'b0;
            end
        endcase
    end

endmodule
